// File: rtl/fifo_umbrales.sv
// fifo_umbrales: 8-deep synchronous FIFO with programmable almost-full/almost-empty thresholds and overflow/underflow error.
// Define FIFO_STICKY_ERR_EN to make error sticky until reset; otherwise error is a one-cycle pulse.
module fifo_umbrales #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [ADDR_WIDTH-1:0] af_thresh,
  input  logic [ADDR_WIDTH-1:0] ae_thresh,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, af_q, af_d, ae_q, ae_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d, err_q, err_d;
  logic                  do_push, do_pop, bad_req;
  always_comb begin
    empty        = count_q == '0;
    full         = count_q == FULL_CNT;
    almost_full  = count_q >= {1'b0, af_q};
    almost_empty = count_q <= {1'b0, ae_q};
    // a pop on a full FIFO frees the slot the simultaneous push lands in
    do_push      = push && (!full || pop);
    do_pop       = pop && !empty;
    bad_req      = (push && full && !pop) || (pop && empty);
    wr_ptr_d     = do_push ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d     = do_pop ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    count_d      = count_q + {{ADDR_WIDTH{1'b0}}, do_push} - {{ADDR_WIDTH{1'b0}}, do_pop};
    data_out_d   = do_pop ? mem[rd_ptr_q] : data_out_q;
    valid_d      = do_pop;
`ifdef FIFO_STICKY_ERR_EN
    err_d        = err_q || bad_req;
`else
    err_d        = bad_req;
`endif
    af_d         = (reset || init) ? af_thresh : af_q;
    ae_d         = (reset || init) ? ae_thresh : ae_q;
    count        = count_q;
    data_out     = data_out_q;
    valid_out    = valid_q;
    error        = err_q;
  end
  always_ff @(posedge clk) begin
    af_q <= af_d;
    ae_q <= ae_d;
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= data_in;
  end
endmodule

// File: tb/tb_fifo_umbrales.sv
// tb_fifo_umbrales: directed test of fifo_umbrales fill/drain, wrap, overflow, underflow, thresholds and reset.
module tb_fifo_umbrales;
  logic       clk = 1'b0;
  logic       reset, init, push, pop, valid_out, empty, full, almost_full, almost_empty, error;
  logic [2:0] af_thresh, ae_thresh;
  logic [5:0] data_in, data_out;
  logic [3:0] count;
  int         checks = 0;
  int         errors = 0;
`ifdef FIFO_STICKY_ERR_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif
  fifo_umbrales dut (
    .clk(clk), .reset(reset), .init(init), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .push(push), .data_in(data_in), .pop(pop), .data_out(data_out), .valid_out(valid_out),
    .count(count), .empty(empty), .full(full), .almost_full(almost_full),
    .almost_empty(almost_empty), .error(error)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic pu, input logic po, input logic [5:0] d);
    push = pu;
    pop = po;
    data_in = d;
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1; init = 1'b0; af_thresh = 3'd6; ae_thresh = 3'd3;
    push = 1'b0; pop = 1'b0; data_in = '0;
    #1;
    cyc(0, 0, 0);
    reset = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_error", error, 0);
    chk("rst_data", data_out, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 0, 6'(i));
      chk("fill_count", count, i);
      chk("fill_ae", almost_empty, i <= 3);
      chk("fill_af", almost_full, i >= 6);
      chk("fill_full", full, i == 8);
      chk("fill_error", error, 0);
    end
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 0);
      chk("drain_data", data_out, i);
      chk("drain_valid", valid_out, 1);
      chk("drain_count", count, 8 - i);
    end
    chk("drain_empty", empty, 1);
    cyc(0, 0, 0);
    chk("idle_valid", valid_out, 0);
    chk("idle_hold", data_out, 8'h08);
    for (int i = 0; i < 3; i++) cyc(1, 0, 6'(8'h11 + i));
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0);
      chk("shift_data", data_out, 8'h11 + i);
    end
    for (int i = 0; i < 8; i++) cyc(1, 0, 6'(8'h20 + i));
    chk("wrap_full", full, 1);
    chk("wrap_count", count, 8);
    cyc(1, 1, 6'h30);
    chk("fullpp_data", data_out, 8'h20);
    chk("fullpp_valid", valid_out, 1);
    chk("fullpp_count", count, 8);
    chk("fullpp_error", error, 0);
    cyc(1, 0, 6'h3F);
    chk("ovf_count", count, 8);
    chk("ovf_error", error, 1);
    cyc(0, 0, 0);
    chk("ovf_after", error, STICKY);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0);
      chk("ovf_drain", data_out, i < 7 ? 8'h21 + i : 8'h30);
      chk("ovf_err_hold", error, STICKY);
    end
    chk("ovf_empty", empty, 1);
    cyc(1, 1, 6'h15);
    chk("udf_count", count, 1);
    chk("udf_valid", valid_out, 0);
    chk("udf_error", error, 1);
    cyc(0, 1, 0);
    chk("udf_next_data", data_out, 8'h15);
    chk("udf_next_valid", valid_out, 1);
    chk("udf_next_err", error, STICKY);
    for (int i = 1; i <= 4; i++) cyc(1, 0, 6'(i));
    chk("th_count", count, 4);
    init = 1'b1; af_thresh = 3'd4; ae_thresh = 3'd5;
    cyc(0, 0, 0);
    chk("th1_af", almost_full, 1);
    chk("th1_ae", almost_empty, 1);
    af_thresh = 3'd7; ae_thresh = 3'd1;
    cyc(0, 0, 0);
    init = 1'b0;
    chk("th2_af", almost_full, 0);
    chk("th2_ae", almost_empty, 0);
    af_thresh = 3'd0; ae_thresh = 3'd7;
    cyc(0, 0, 0);
    chk("th_hold_af", almost_full, 0);
    chk("th_hold_ae", almost_empty, 0);
    cyc(1, 0, 6'h05);
    chk("mid_count", count, 5);
    reset = 1'b1; af_thresh = 3'd0; ae_thresh = 3'd0;
    cyc(1, 1, 6'h2A);
    reset = 1'b0;
    chk("mrst_count", count, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_valid", valid_out, 0);
    chk("mrst_error", error, 0);
    chk("af0_af", almost_full, 1);
    chk("ae0_ae", almost_empty, 1);
    cyc(1, 0, 6'h2C);
    chk("post_count", count, 1);
    chk("af0_af1", almost_full, 1);
    chk("ae0_ae1", almost_empty, 0);
    cyc(0, 1, 0);
    chk("post_data", data_out, 8'h2C);
    chk("post_empty", empty, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
